// File: rtl/sign_job_ctrl.sv
// Job sequencer for a signing core: accepts a job, starts the core, guards it with a
// busy watchdog and holds the signature until taken. Optional compare: SIGN_JOB_CHECK_EN.
module sign_job_ctrl #(
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_sk,
  input  logic [255:0] job_pk,
  input  logic [255:0] job_m,
`ifdef SIGN_JOB_CHECK_EN
  input  logic [255:0] job_exp_r,
  input  logic [255:0] job_exp_s,
  output logic         res_mismatch,
`endif
  input  logic         core_ready,
  input  logic         core_comp_done,
  output logic         core_ena,
  output logic [255:0] core_sk,
  output logic [255:0] core_pk,
  output logic [255:0] core_M,
  input  logic [255:0] core_R,
  input  logic [255:0] core_S,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [255:0] res_r,
  output logic [255:0] res_s,
  output logic         res_err,
  output logic [15:0]  job_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_RDY = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] BUSY     = 3'd3;
  localparam logic [2:0] RESULT   = 3'd4;

  // Abort on the edge where the watchdog would reach TIMEOUT_MAX, i.e. after
  // exactly TIMEOUT_MAX cycles spent in BUSY.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_MAX - TIMEOUT_W'(1);

  logic [2:0]           state;
  logic [TIMEOUT_W-1:0] wd;

  assign job_ready = (state == IDLE);
  assign core_ena  = (state == ISSUE);
  assign res_valid = (state == RESULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wd        <= '0;
      res_r     <= '0;
      res_s     <= '0;
      res_err   <= 1'b0;
      job_count <= '0;
      core_sk   <= '0;
      core_pk   <= '0;
      core_M    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            core_sk <= job_sk;
            core_pk <= job_pk;
            core_M  <= job_m;
            state   <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (core_ready) state <= ISSUE;
        end
        ISSUE: begin
          wd    <= '0;
          state <= BUSY;
        end
        BUSY: begin
          wd <= wd + TIMEOUT_W'(1);
          // A completion on the timeout edge still delivers the real signature.
          if (core_comp_done) begin
            res_r   <= core_R;
            res_s   <= core_S;
            res_err <= 1'b0;
            state   <= RESULT;
          end else if (wd == WD_LAST) begin
            res_r   <= '0;
            res_s   <= '0;
            res_err <= 1'b1;
            state   <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            job_count <= job_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIGN_JOB_CHECK_EN
  logic [255:0] exp_r;
  logic [255:0] exp_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= '0;
      exp_s <= '0;
    end else if (state == IDLE && job_valid) begin
      exp_r <= job_exp_r;
      exp_s <= job_exp_s;
    end
  end

  assign res_mismatch = (state == RESULT) && !res_err &&
                        ((res_r != exp_r) || (res_s != exp_s));
`endif

endmodule

// File: tb/tb_sign_job_ctrl.sv
// Scoreboard bench for sign_job_ctrl with a behavioural signing-core model.
module tb_sign_job_ctrl;

  localparam int              TW   = 20;
  localparam logic [TW-1:0]   TMAX = 20'd16;

  logic         clk;
  logic         rst_n;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_sk, job_pk, job_m;
  logic [255:0] job_exp_r, job_exp_s;
  logic         core_ready, core_comp_done, core_ena;
  logic [255:0] core_sk, core_pk, core_M, core_R, core_S;
  logic         res_valid, res_ready, res_err;
  logic [255:0] res_r, res_s;
  logic [15:0]  job_count;
`ifdef SIGN_JOB_CHECK_EN
  logic         res_mismatch;
`endif

  sign_job_ctrl #(.TIMEOUT_W(TW), .TIMEOUT_MAX(TMAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_sk         (job_sk),
    .job_pk         (job_pk),
    .job_m          (job_m),
`ifdef SIGN_JOB_CHECK_EN
    .job_exp_r      (job_exp_r),
    .job_exp_s      (job_exp_s),
    .res_mismatch   (res_mismatch),
`endif
    .core_ready     (core_ready),
    .core_comp_done (core_comp_done),
    .core_ena       (core_ena),
    .core_sk        (core_sk),
    .core_pk        (core_pk),
    .core_M         (core_M),
    .core_R         (core_R),
    .core_S         (core_S),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_r          (res_r),
    .res_s          (res_s),
    .res_err        (res_err),
    .job_count      (job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] r;
    logic [255:0] s;
    logic         err;
    logic         mm;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = '0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Core model: result appears model_lat cycles after the core_ena cycle.
  int           model_lat     = 1;
  bit           model_hang    = 1'b0;
  bit           model_derived = 1'b0;
  logic [255:0] model_r       = {128{2'b10}};
  logic [255:0] model_s       = {128{2'b01}};
  int           m_cnt         = 0;

  initial begin
    core_comp_done = 1'b0;
    core_R = '0;
    core_S = '0;
    forever begin
      @(negedge clk);
      if (m_cnt > 0) begin
        m_cnt--;
        core_comp_done = (m_cnt == 0);
        if (m_cnt == 0) begin
          core_R = model_derived ? (core_sk ^ core_M) : model_r;
          core_S = model_derived ? (core_pk + core_M) : model_s;
        end
      end else begin
        core_comp_done = 1'b0;
      end
      if (core_ena && !model_hang) m_cnt = model_lat;
    end
  end

  task automatic push_exp(input logic [255:0] xr, input logic [255:0] xs, input logic xerr);
    exp_t e;
    e.r   = xr;
    e.s   = xs;
    e.err = xerr;
    e.mm  = !xerr && ((xr != job_exp_r) || (xs != job_exp_s));
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic send_job(input logic [255:0] sk, input logic [255:0] pk, input logic [255:0] m,
                          input logic [255:0] er, input logic [255:0] es,
                          input logic [255:0] xr, input logic [255:0] xs, input logic xerr);
    int n;
    job_sk = sk; job_pk = pk; job_m = m;
    job_exp_r = er; job_exp_s = es;
    job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("job_accept", 256'(job_ready), 256'(1));
    @(negedge clk);
    job_valid = 1'b0;
    push_exp(xr, xs, xerr);
  endtask

  task automatic get_result(input string tag, input int hold, output int lat);
    int           n;
    exp_t         e;
    logic [255:0] r0, s0;
    logic         e0;
    bit           stable;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check_val({tag, "_valid"}, 256'(res_valid), 256'(1));
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 256'(0), 256'(1));
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_r"}, res_r, e.r);
      check_val({tag, "_s"}, res_s, e.s);
      check_val({tag, "_err"}, 256'(res_err), 256'(e.err));
`ifdef SIGN_JOB_CHECK_EN
      check_val({tag, "_mismatch"}, 256'(res_mismatch), 256'(e.mm));
`endif
    end
    r0 = res_r; s0 = res_s; e0 = res_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res_r !== r0 || res_s !== s0 || res_err !== e0 || !res_valid || job_ready) stable = 1'b0;
    end
    if (hold > 0) check_val({tag, "_hold"}, 256'(stable), 256'(1));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_cnt++;
    check_val({tag, "_count"}, 256'(job_count), 256'(exp_cnt));
    check_val({tag, "_released"}, 256'(res_valid), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int           lat;
    int           n;
    bit           ok;
    logic [255:0] skb, pkb, mb;

    rst_n = 1'b1; job_valid = 1'b0; res_ready = 1'b0; core_ready = 1'b1;
    job_sk = '0; job_pk = '0; job_m = '0; job_exp_r = '0; job_exp_s = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_core_ena", 256'(core_ena), 256'(0));
    check_val("rst_res_valid", 256'(res_valid), 256'(0));
    check_val("rst_res_err", 256'(res_err), 256'(0));
    check_val("rst_job_count", 256'(job_count), 256'(0));
    check_val("rst_res_r", res_r, 256'(0));
    check_val("rst_core_sk", core_sk, 256'(0));

    // A job offered while reset is held must not be taken.
    job_valid = 1'b1; job_sk = 256'd9; job_pk = 256'd9; job_m = 256'd9;
    repeat (2) @(negedge clk);
    check_val("rst_no_accept", core_sk, 256'(0));
    job_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single job with fixed AA../55.. signature, 10-cycle core.
    model_lat = 10;
    send_job(256'd1, 256'd2, 256'd3, model_r, model_s, model_r, model_s, 1'b0);
    check_val("single_core_sk", core_sk, 256'd1);
    check_val("single_core_pk", core_pk, 256'd2);
    check_val("single_core_M", core_M, 256'd3);
    get_result("single", 0, lat);
    check_val("single_latency", 256'(lat), 256'(12));

    // Minimum latency, operand-derived results.
    model_derived = 1'b1; model_lat = 1;
    skb = {64{4'h3}}; pkb = 256'h1234_5678; mb = {32{8'hC5}};
    send_job(skb, pkb, mb, skb ^ mb, pkb + mb, skb ^ mb, pkb + mb, 1'b0);
    get_result("min_a", 0, lat);
    check_val("min_a_latency", 256'(lat), 256'(3));
    skb = 256'hDEAD_BEEF; pkb = {128{2'b11}}; mb = 256'h7;
    send_job(skb, pkb, mb, skb ^ mb, pkb + mb, skb ^ mb, pkb + mb, 1'b0);
    get_result("min_b", 0, lat);
    check_val("min_b_latency", 256'(lat), 256'(3));
    check_val("operands_held", core_sk, skb);

    // Core not ready for 50 cycles.
    core_ready = 1'b0;
    send_job(256'd11, 256'd12, 256'd13, 256'd0, 256'd0, 256'd11 ^ 256'd13, 256'd25, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (core_ena) ok = 1'b0;
      @(negedge clk);
    end
    check_val("wait_rdy_no_ena", 256'(ok), 256'(1));
    core_ready = 1'b1;
    @(negedge clk);
    check_val("wait_rdy_ena_pulse", 256'(core_ena), 256'(1));
    @(negedge clk);
    check_val("wait_rdy_ena_single", 256'(core_ena), 256'(0));
    get_result("wait_rdy", 0, lat);

    // Result back-pressure while the next job is already offered.
    send_job(256'd21, 256'd22, 256'd23, 256'd0, 256'd0, 256'd21 ^ 256'd23, 256'd45, 1'b0);
    skb = 256'hAB; pkb = 256'hCD; mb = 256'hEF;
    job_sk = skb; job_pk = pkb; job_m = mb; job_valid = 1'b1;
    get_result("backpressure", 20, lat);
    check_val("next_job_ready", 256'(job_ready), 256'(1));
    @(negedge clk);
    check_val("next_job_taken", 256'(job_ready), 256'(0));
    check_val("next_job_sk", core_sk, skb);
    job_valid = 1'b0;
    push_exp(skb ^ mb, pkb + mb, 1'b0);
    get_result("next_job", 0, lat);

    // Watchdog timeout: core never completes.
    model_hang = 1'b1;
    send_job(256'd5, 256'd6, 256'd7, 256'd0, 256'd0, 256'd0, 256'd0, 1'b1);
    n = 0;
    while (!core_ena && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("timeout_ena_seen", 256'(core_ena), 256'(1));
    @(negedge clk);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("timeout_busy_cycles", 256'(n), 256'(TMAX));
    get_result("timeout", 0, lat);
    model_hang = 1'b0;

    // Reset asserted mid-BUSY; the late completion must be ignored.
    model_derived = 1'b0; model_lat = 10;
    send_job(256'd31, 256'd32, 256'd33, model_r, model_s, model_r, model_s, 1'b0);
    n = 0;
    while (!core_ena && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_core_ena", 256'(core_ena), 256'(0));
    check_val("midrst_job_ready", 256'(job_ready), 256'(1));
    check_val("midrst_res_err", 256'(res_err), 256'(0));
    check_val("midrst_job_count", 256'(job_count), 256'(0));
    check_val("midrst_res_r", res_r, 256'(0));
    check_val("midrst_core_sk", core_sk, 256'(0));
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid || !job_ready || core_ena) ok = 1'b0;
    end
    check_val("midrst_done_ignored", 256'(ok), 256'(1));
    check_val("midrst_count_after", 256'(job_count), 256'(0));

    // Recovery job, then one with a one-bit expected-S difference.
    model_lat = 2;
    send_job(256'd41, 256'd42, 256'd43, model_r, model_s, model_r, model_s, 1'b0);
    get_result("post_rst", 0, lat);
    send_job(256'd51, 256'd52, 256'd53, model_r, model_s ^ 256'd1, model_r, model_s, 1'b0);
    get_result("exp_diff", 0, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sign_job_ctrl.md
SIGN_JOB_CTRL -- requirements
Module: sign_job_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 20, width of the busy watchdog counter.
REQ-002 SHALL have parameter TIMEOUT_MAX, default 20'hFFFFF, BUSY cycles before timeout abort.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 job_valid/job_ready  in/out  1/1  job handshake; transfer when both are high at a clk edge.
REQ-006 job_sk, job_pk, job_m  in  256 each  secret key, public key and message of the job.
REQ-007 core_ready, core_comp_done  in  1 each  signing-core status: idle/accepting, and result-valid.
REQ-008 core_ena  out  1  one-cycle start strobe to the core.
REQ-009 core_sk, core_pk, core_M  out  256 each  latched job operands to the core.
REQ-010 core_R, core_S  in  256 each  core signature halves, valid while core_comp_done is high.
REQ-011 res_valid/res_ready  out/in  1/1  result handshake.
REQ-012 res_r, res_s  out  256 each  captured signature; res_err  out  1  timeout flag.
REQ-013 job_count  out  16  number of completed result handshakes, wraps 16'hFFFF->0.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_RDY, ISSUE, BUSY, RESULT.
REQ-015 job_ready SHALL be high only in IDLE; on transfer, operands latch to core_* and the FSM goes to WAIT_RDY.
REQ-016 WAIT_RDY: when core_ready=1 go to ISSUE; otherwise stay, with no limit.
REQ-017 ISSUE: core_ena=1 for exactly this one cycle; next state BUSY; watchdog cleared to 0.
REQ-018 core_ena SHALL be 0 in every state other than ISSUE.
REQ-019 BUSY: watchdog increments each cycle; core_comp_done=1 captures core_R/core_S into res_r/res_s, res_err=0, go to RESULT.
REQ-020 BUSY: watchdog reaching TIMEOUT_MAX with no core_comp_done SHALL set res_r=res_s=0, res_err=1 and go to RESULT; when both occur in the same cycle, core_comp_done wins.
REQ-021 RESULT: res_valid=1; res_r/res_s/res_err SHALL stay stable until res_ready=1, then job_count increments and the FSM goes to IDLE.
REQ-022 Minimum job latency: job transfer to res_valid = 3 cycles + core compute time (core_ready already high, core_comp_done one cycle after core_ena).
REQ-023 core_comp_done outside BUSY SHALL be ignored and leave no state change.
REQ-024 core_sk/pk/M SHALL hold the last accepted job until the next job transfer.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, core_ena=0, res_valid=0, res_err=0, job_count=0, res_r=res_s=0, core_sk=core_pk=core_M=0, watchdog=0.
REQ-026 Reset mid-operation (any state) SHALL abandon the job; no result is produced for it.
REQ-027 The first job SHALL be accepted no earlier than the first clk edge after rst_n is deasserted.

Configuration
REQ-028 Macro SIGN_JOB_CHECK_EN, when defined, SHALL add inputs job_exp_r and job_exp_s (256 each, latched with the job) and output res_mismatch (1).
REQ-029 With SIGN_JOB_CHECK_EN: res_mismatch=1 in RESULT iff res_err=0 and (res_r!=exp_r or res_s!=exp_s); res_mismatch is 0 on timeout and after reset.
REQ-030 Without SIGN_JOB_CHECK_EN: these ports and the compare logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Single job, sk=1, pk=2, m=3, core model returns R=0xAA..AA, S=0x55..55 ten cycles after core_ena -> res_valid with those values, res_err=0, job_count=1.
REQ-032 core_ready held low 50 cycles after job transfer -> core_ena stays 0 for all 50 cycles, then pulses exactly one cycle after core_ready rises.
REQ-033 TIMEOUT_MAX=16, core never raises core_comp_done -> res_valid 16 cycles after core_ena, res_err=1, res_r=res_s=0.
REQ-034 res_ready held low 20 cycles in RESULT while job_valid=1 -> job_ready=0 throughout, result stable; after res_ready, next job accepted one cycle later.
REQ-035 rst_n pulsed low during BUSY -> outputs reset immediately; a later core_comp_done is ignored; job_count=0.
REQ-036 With SIGN_JOB_CHECK_EN, exp_s differs by one bit from core_S -> res_mismatch=1; a matching job gives res_mismatch=0.
